// File: rtl/karatsuba_mul_arbiter_if.sv
// Request/response bundle for the two-requester shared Karatsuba multiplier.
// The design takes the slave view; the requesters and the product consumer take the master view.
interface karatsuba_mul_arbiter_if;
  logic        req0_valid;
  logic        req1_valid;
  logic        req0_ready;
  logic        req1_ready;
  logic [15:0] req0_a;
  logic [15:0] req0_b;
  logic [15:0] req1_a;
  logic [15:0] req1_b;
  logic        resp_valid;
  logic        resp_ready;
  logic        resp_id;
  logic [31:0] resp_z;
  logic        busy;

  modport slave (
    input  req0_valid, req1_valid, req0_a, req0_b, req1_a, req1_b, resp_ready,
    output req0_ready, req1_ready, resp_valid, resp_id, resp_z, busy
  );

  modport master (
    output req0_valid, req1_valid, req0_a, req0_b, req1_a, req1_b, resp_ready,
    input  req0_ready, req1_ready, resp_valid, resp_id, resp_z, busy
  );
endinterface

// File: rtl/karatsuba_mul_arbiter.sv
// Round-robin arbiter in front of a single combinational 16x16 Karatsuba multiplier.
// Operands are registered on accept, given CALC_CYCLES to settle, then held until the consumer takes them.
module karatsuba_16 (
  input  logic [15:0] a,
  input  logic [15:0] b,
  output logic [31:0] z
);
  logic [7:0]  ah, al, bh, bl;
  logic [15:0] z0, z2;
  logic [8:0]  sa, sb;
  logic [17:0] z1_full, z1;

  always_comb begin
    ah      = a[15:8];
    al      = a[7:0];
    bh      = b[15:8];
    bl      = b[7:0];
    z0      = 16'(al) * 16'(bl);
    z2      = 16'(ah) * 16'(bh);
    sa      = {1'b0, ah} + {1'b0, al};
    sb      = {1'b0, bh} + {1'b0, bl};
    z1_full = 18'(sa) * 18'(sb);
    // middle term (ah*bl + al*bh) recovered from the sum product; always fits in 17 bits
    z1      = z1_full - {2'b00, z2} - {2'b00, z0};
    z       = {z2, 16'h0000} + ({14'h0000, z1} << 8) + {16'h0000, z0};
  end
endmodule

module karatsuba_mul_arbiter #(
  parameter int unsigned CALC_CYCLES = 2
) (
  input  logic                          clk,
  input  logic                          rst,
  karatsuba_mul_arbiter_if.slave        bus
);
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam logic [3:0] CNT_LOAD = 4'(CALC_CYCLES - 1);

  state_t      state, state_next;
  logic [15:0] op_a, op_b;
  logic        id;
  logic        last_grant;
  logic [3:0]  counter;
  logic [31:0] prod;
  logic [31:0] resp_z_q;
  logic        resp_id_q;
  logic        grant;
  logic        accept;
  logic        ready0, ready1;

  karatsuba_16 u_mul (
    .a (op_a),
    .b (op_b),
    .z (prod)
  );

  always_comb begin
    state_next = state;
    grant      = 1'b0;
    ready0     = 1'b0;
    ready1     = 1'b0;
    accept     = 1'b0;
    case (state)
      IDLE: begin
        if (!rst) begin
          // tie goes to whoever was not served last; a lone requester always wins
          if (bus.req0_valid && bus.req1_valid) grant = ~last_grant;
          else                                  grant = bus.req1_valid;
          ready0 = bus.req0_valid && !grant;
          ready1 = bus.req1_valid &&  grant;
          accept = ready0 || ready1;
          if (accept) state_next = CALC;
        end
      end
      CALC: if (counter == 4'd0) state_next = RESP;
      RESP: if (bus.resp_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      op_a       <= '0;
      op_b       <= '0;
      id         <= 1'b0;
      last_grant <= 1'b1;
      counter    <= '0;
      resp_z_q   <= '0;
      resp_id_q  <= 1'b0;
    end else begin
      state <= state_next;
      if (accept) begin
        op_a       <= grant ? bus.req1_a : bus.req0_a;
        op_b       <= grant ? bus.req1_b : bus.req0_b;
        id         <= grant;
        last_grant <= grant;
        counter    <= CNT_LOAD;
      end else if (state == CALC) begin
        if (counter == 4'd0) begin
          resp_z_q  <= prod;
          resp_id_q <= id;
        end else begin
          counter <= counter - 4'd1;
        end
      end
    end
  end

  always_comb begin
    bus.req0_ready = ready0;
    bus.req1_ready = ready1;
    bus.resp_valid = (state == RESP);
    bus.resp_z     = resp_z_q;
    bus.resp_id    = resp_id_q;
    bus.busy       = (state != IDLE);
  end
endmodule

// File: tb/tb_karatsuba_mul_arbiter.sv
// Directed bench for karatsuba_mul_arbiter: reset state, single ops, carry corners,
// round-robin contention, response backpressure and reset during a calculation.
module tb_karatsuba_mul_arbiter;
  localparam int unsigned CC = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;

  karatsuba_mul_arbiter_if bus ();

  karatsuba_mul_arbiter #(.CALC_CYCLES(CC)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic idle_inputs();
    bus.req0_valid = 1'b0;
    bus.req1_valid = 1'b0;
    bus.resp_ready = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    idle_inputs();
    tick();
    tick();
    rst = 1'b0;
  endtask

  // waits (bounded) for resp_valid, returns number of edges waited
  task automatic wait_resp(output int lat);
    lat = 0;
    while (!bus.resp_valid && lat < 40) begin
      tick();
      lat++;
    end
  endtask

  task automatic run_op(input logic idx, input logic [15:0] a, input logic [15:0] b,
                        input logic [31:0] exp_z, input string tag);
    int n;
    int lat;
    if (idx == 1'b0) begin
      bus.req0_a = a; bus.req0_b = b; bus.req0_valid = 1'b1;
    end else begin
      bus.req1_a = a; bus.req1_b = b; bus.req1_valid = 1'b1;
    end
    #1;
    n = 0;
    while (!(idx ? bus.req1_ready : bus.req0_ready) && n < 20) begin
      tick();
      n++;
    end
    check({tag, "_accepted"}, 32'(n < 20), 32'd1);
    tick();
    bus.req0_valid = 1'b0;
    bus.req1_valid = 1'b0;
    check({tag, "_busy_calc"}, 32'(bus.busy), 32'd1);
    wait_resp(lat);
    check({tag, "_latency"}, 32'(lat), 32'(CC));
    check({tag, "_z"}, bus.resp_z, exp_z);
    check({tag, "_id"}, 32'(bus.resp_id), 32'(idx));
    bus.resp_ready = 1'b1;
    tick();
    bus.resp_ready = 1'b0;
    check({tag, "_idle_after"}, 32'(bus.busy), 32'd0);
  endtask

  initial begin : stim
    int acc_id [4];
    int acc_cyc[4];
    int nacc;
    int both_hi;
    int lat;

    bus.req0_a = '0; bus.req0_b = '0; bus.req1_a = '0; bus.req1_b = '0;
    idle_inputs();

    // reset state, with a requester already asserting valid
    bus.req0_valid = 1'b1;
    tick();
    tick();
    check("rst_ready0", 32'(bus.req0_ready), 32'd0);
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_resp_valid", 32'(bus.resp_valid), 32'd0);
    check("rst_resp_z", bus.resp_z, 32'd0);
    check("rst_resp_id", 32'(bus.resp_id), 32'd0);
    bus.req0_valid = 1'b0;
    do_reset();

    // first accept possible in the first cycle after reset
    run_op(1'b0, 16'h1234, 16'h5678, 32'h0626_0060, "single0");
    run_op(1'b1, 16'h00FF, 16'h00FF, 32'h0000_FE01, "single1");
    run_op(1'b0, 16'h8000, 16'h0002, 32'h0001_0000, "shift");

    // contention: grants alternate starting with req0, accepts CC+2 apart
    do_reset();
    bus.req0_a = 16'd3; bus.req0_b = 16'd7;
    bus.req1_a = 16'd9; bus.req1_b = 16'd11;
    bus.req0_valid = 1'b1;
    bus.req1_valid = 1'b1;
    bus.resp_ready = 1'b1;
    #1;
    nacc = 0;
    both_hi = 0;
    for (int i = 0; i < 40 && nacc < 4; i++) begin
      if (bus.req0_ready && bus.req1_ready) both_hi++;
      if (bus.req0_ready || bus.req1_ready) begin
        acc_id[nacc]  = bus.req1_ready ? 1 : 0;
        acc_cyc[nacc] = cyc;
        nacc++;
      end
      if (bus.resp_valid) check("cont_z", bus.resp_z, bus.resp_id ? 32'd99 : 32'd21);
      tick();
    end
    check("cont_count", 32'(nacc), 32'd4);
    check("cont_never_both", 32'(both_hi), 32'd0);
    check("cont_g0", 32'(acc_id[0]), 32'd0);
    check("cont_g1", 32'(acc_id[1]), 32'd1);
    check("cont_g2", 32'(acc_id[2]), 32'd0);
    check("cont_g3", 32'(acc_id[3]), 32'd1);
    for (int i = 1; i < 4; i++)
      check("cont_spacing", 32'(acc_cyc[i] - acc_cyc[i-1]), 32'(CC + 2));

    // backpressure with carry-heavy operands from req1
    do_reset();
    bus.req1_a = 16'hFFFF; bus.req1_b = 16'hFFFF; bus.req1_valid = 1'b1;
    #1;
    check("bp_ready1", 32'(bus.req1_ready), 32'd1);
    tick();
    bus.req1_valid = 1'b0;
    bus.req1_a = 16'h0001; bus.req1_b = 16'h0001;
    wait_resp(lat);
    check("bp_latency", 32'(lat), 32'(CC));
    bus.req0_a = 16'h0000; bus.req0_b = 16'hBEEF; bus.req0_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      #1;
      check("bp_valid", 32'(bus.resp_valid), 32'd1);
      check("bp_z", bus.resp_z, 32'hFFFE_0001);
      check("bp_id", 32'(bus.resp_id), 32'd1);
      check("bp_ready0", 32'(bus.req0_ready), 32'd0);
      check("bp_busy", 32'(bus.busy), 32'd1);
      tick();
    end
    bus.resp_ready = 1'b1;
    #1;
    check("bp_hs_ready0", 32'(bus.req0_ready), 32'd0);
    tick();
    bus.resp_ready = 1'b0;
    #1;
    check("bp_after_busy", 32'(bus.busy), 32'd0);
    check("bp_after_ready0", 32'(bus.req0_ready), 32'd1);
    tick();
    bus.req0_valid = 1'b0;
    wait_resp(lat);
    check("zero_z", bus.resp_z, 32'h0000_0000);
    check("zero_id", 32'(bus.resp_id), 32'd0);
    bus.resp_ready = 1'b1;
    tick();
    bus.resp_ready = 1'b0;

    // reset mid-CALC discards the operation
    do_reset();
    bus.req1_a = 16'h00FF; bus.req1_b = 16'h0100; bus.req1_valid = 1'b1;
    tick();
    bus.req1_valid = 1'b0;
    check("mid_busy", 32'(bus.busy), 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("mid_rst_busy", 32'(bus.busy), 32'd0);
    lat = 0;
    for (int i = 0; i < 6; i++) begin
      if (bus.resp_valid) lat++;
      tick();
    end
    check("mid_no_resp", 32'(lat), 32'd0);
    bus.req0_a = 16'h0003; bus.req0_b = 16'h0005; bus.req0_valid = 1'b1;
    bus.req1_a = 16'h0009; bus.req1_b = 16'h0009; bus.req1_valid = 1'b1;
    #1;
    check("mid_tie_ready0", 32'(bus.req0_ready), 32'd1);
    check("mid_tie_ready1", 32'(bus.req1_ready), 32'd0);
    tick();
    bus.req0_valid = 1'b0;
    bus.req1_valid = 1'b0;
    wait_resp(lat);
    check("mid_latency", 32'(lat), 32'(CC));
    check("mid_z", bus.resp_z, 32'h0000_000F);
    check("mid_id", 32'(bus.resp_id), 32'd0);
    bus.resp_ready = 1'b1;
    tick();
    bus.resp_ready = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/karatsuba_mul_arbiter.md
KARATSUBA_MUL_ARBITER -- requirements
Module: karatsuba_mul_arbiter

Interface
REQ-001 SHALL have parameter CALC_CYCLES, default 2: settle cycles for the shared combinational karatsuba_16 between operand capture and result capture; legal range 1..15.
REQ-002 SHALL have port clk  input  1  single clock, rising edge.
REQ-003 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-004 SHALL have ports req0_valid, req1_valid  input  1 each  requester has operands.
REQ-005 SHALL have ports req0_ready, req1_ready  output  1 each  operands accepted this cycle.
REQ-006 SHALL have ports req0_a, req0_b, req1_a, req1_b  input  16 each  unsigned operands.
REQ-007 SHALL have port resp_valid  output  1  product available.
REQ-008 SHALL have port resp_ready  input  1  consumer takes product.
REQ-009 SHALL have port resp_id  output  1  requester index owning resp_z.
REQ-010 SHALL have port resp_z  output  32  unsigned product.
REQ-011 SHALL have port busy  output  1  high whenever state is not IDLE.

Function
REQ-012 SHALL contain exactly one karatsuba_16 instance, fed only from internal operand registers op_a/op_b.
REQ-013 SHALL implement FSM states IDLE, CALC, RESP.
REQ-014 IDLE: reqN_ready driven combinationally, high only for the granted requester, only in IDLE; never both high.
REQ-015 Grant rule: one valid -> that requester; both valid -> the one not granted last (round-robin via last_grant register).
REQ-016 Accept on reqN_valid & reqN_ready at edge k: capture a/b into op_a/op_b, N into id, update last_grant=N, load counter with CALC_CYCLES-1, go CALC.
REQ-017 CALC: counter decrements each cycle; at edge with counter==0, register karatsuba_16 output into resp_z, id into resp_id, go RESP; resp_valid first high in cycle after edge k+CALC_CYCLES.
REQ-018 RESP: resp_valid=1; resp_z and resp_id held stable until resp_ready; on resp_valid & resp_ready go IDLE.
REQ-019 No request SHALL be accepted in CALC or RESP or in the RESP handshake cycle; minimum spacing between accepts is CALC_CYCLES+2 cycles.
REQ-020 resp_z SHALL equal op_a*op_b exactly, full 32-bit unsigned, no truncation.
REQ-021 Requester dropping valid before ready: no state change, no grant recorded.
REQ-022 Operand inputs are ignored outside the accept cycle; op_a/op_b SHALL not change in CALC or RESP.

Reset
REQ-023 While rst high at a rising edge: state=IDLE, resp_valid=0, resp_z=0, resp_id=0, counter=0, op_a=op_b=0, last_grant=1 (req0 wins first tie); busy=0, both ready=0 during reset.
REQ-024 Reset in CALC or RESP SHALL discard the operation; no resp_valid for it afterward.
REQ-025 First accept possible in first cycle after rst deasserts.

Verification
REQ-026 Single op, CALC_CYCLES=2: req0 a=0x1234 b=0x5678 accepted at edge k -> resp_valid from cycle after edge k+2, resp_z=0x06260060, resp_id=0.
REQ-027 Carry stress: req1 a=0xFFFF b=0xFFFF -> resp_z=0xFFFE0001, resp_id=1; also a=0x0000 b=0xBEEF -> resp_z=0x00000000.
REQ-028 Contention: both valid continuously after reset, resp_ready=1 -> grants 0,1,0,1; accepts spaced exactly 4 cycles apart.
REQ-029 Backpressure: resp_ready low 5 cycles in RESP -> resp_valid, resp_z, resp_id stable, both ready low, busy high; IDLE cycle after handshake.
REQ-030 Reset mid-CALC after accepting 0x00FF*0x0100 -> no resp_valid; next op 0x0003*0x0005 returns 0x0000000F, req0 granted on tie.
